// File: rtl/latch_bank_write_arbiter.sv
// rtl/latch_bank_write_arbiter.sv - round-robin write arbiter for a shared latch bank
// Sequences setup / enable pulse / hold around each granted write; all outputs registered.
module latch_bank_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  localparam int GNT_W    = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       lat_d,
  output logic                   lat_c,
  output logic                   busy,
  output logic [GNT_W-1:0]       gnt_id
);

  localparam int CNT_MAX = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_ACK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             lat_c_q, lat_c_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [WIDTH-1:0] wslice [N_REQ];
  logic             arb_found;
  logic [GNT_W-1:0] arb_idx, arb_pick;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      wslice[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // First requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_idx   = '0;
    for (int o = 0; o < N_REQ; o++) begin
      arb_idx = GNT_W'((int'(ptr_q) + o) % N_REQ);
      if (!arb_found && req[arb_idx]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    lat_d_d = lat_d_q;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_SETUP;
          gnt_d   = arb_pick;
          lat_d_d = wslice[arb_pick];
        end
      end
      S_SETUP: begin
        state_d = S_ENABLE;
        cnt_d   = CNT_W'(PULSE_CYC - 1);
      end
      S_ENABLE: begin
        if (cnt_q == '0) begin
          if (HOLD_CYC == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_HOLD;
            cnt_d   = CNT_W'(HOLD_CYC - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        ptr_d   = (gnt_q == GNT_W'(N_REQ - 1)) ? '0 : gnt_q + GNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    lat_c_d = (state_d == S_ENABLE);
    busy_d  = (state_d != S_IDLE);
    ack_d   = '0;
    if (state_d == S_ACK) begin
      ack_d[gnt_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      lat_d_q <= '0;
      lat_c_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      lat_d_q <= lat_d_d;
      lat_c_q <= lat_c_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign ack    = ack_q;
  assign lat_d  = lat_d_q;
  assign lat_c  = lat_c_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// tb/tb_latch_bank_write_arbiter.sv - scoreboard bench for latch_bank_write_arbiter
// Two instances: defaults (PULSE 1, HOLD 1) and PULSE 3, HOLD 0.
module tb_latch_bank_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;
  int          phase  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_env
    localparam int P = (k == 0) ? 1 : 3;
    localparam int H = (k == 0) ? 1 : 0;

    typedef struct {
      int          id;
      logic [W-1:0] data;
      int unsigned gcyc;
    } exp_t;

    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   ack;
    logic [W-1:0]   lat_d;
    logic           lat_c;
    logic           busy;
    logic [1:0]     gnt_id;

    exp_t         exp_q[$];
    int           ptr        = 0;
    int unsigned  next_free  = 0;
    int           n_done     = 0;
    logic [W-1:0] last_data  = '0;
    int           last_id    = 0;
    int           last_phase = -1;
    string        pfx;

    initial pfx = $sformatf("i%0d", k);

    latch_bank_write_arbiter #(
      .N_REQ(N), .WIDTH(W), .PULSE_CYC(P), .HOLD_CYC(H)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .ack(ack),
      .lat_d(lat_d), .lat_c(lat_c), .busy(busy), .gnt_id(gnt_id)
    );

    // Reference: a grant may happen at edge cyc+1 once the previous write's
    // full slot (setup, pulse, hold, ack, idle) has elapsed.
    always @(posedge clk) begin
      if (!rst_n) begin
        ptr       = 0;
        next_free = 0;
        exp_q.delete();
      end else if ((cyc + 1 >= next_free) && (req != '0)) begin
        int id;
        id = -1;
        for (int o = 0; o < N; o++) begin
          if (id < 0 && req[(ptr + o) % N]) id = (ptr + o) % N;
        end
        exp_q.push_back('{id, wdata[id*W +: W], cyc + 1});
        ptr       = (id + 1) % N;
        next_free = cyc + 1 + P + H + 3;
      end
    end

    // Monitor: offset 0 is the setup cycle, 1..P the pulse, P+H+1 the ack.
    always @(negedge clk) begin
      if (!rst_n) begin
        last_data = '0;
        last_id   = 0;
      end else begin
        logic         exp_busy;
        logic         exp_c;
        logic [N-1:0] exp_ack;
        logic [W-1:0] exp_d;
        int           exp_id;
        int           off;
        exp_busy = 1'b0;
        exp_c    = 1'b0;
        exp_ack  = '0;
        exp_d    = last_data;
        exp_id   = last_id;
        off      = -1;
        if (exp_q.size() != 0) begin
          off      = int'(cyc - exp_q[0].gcyc);
          exp_busy = 1'b1;
          exp_c    = (off >= 1) && (off <= P);
          exp_d    = exp_q[0].data;
          exp_id   = exp_q[0].id;
          if (off == P + H + 1) exp_ack[exp_q[0].id] = 1'b1;
        end
        check({pfx, " busy"},   64'(busy),   64'(exp_busy));
        check({pfx, " lat_c"},  64'(lat_c),  64'(exp_c));
        check({pfx, " ack"},    64'(ack),    64'(exp_ack));
        check({pfx, " lat_d"},  64'(lat_d),  64'(exp_d));
        check({pfx, " gnt_id"}, 64'(gnt_id), 64'(exp_id));
        if (off >= P + H + 1) begin
          last_data = exp_d;
          last_id   = exp_id;
          void'(exp_q.pop_front());
          n_done++;
        end
      end
    end

    // Requesters: drop req the edge after ack (occasionally keep it as a new request).
    always @(negedge clk) begin
      if (!rst_n) begin
        req   = N'($urandom);
        wdata = (N*W)'($urandom);
      end else begin
        if (phase != last_phase) begin
          last_phase = phase;
          case (phase)
            0: req = '0;
            1: begin
              req = 4'b0100;
              wdata[2*W +: W] = 8'hA5;
            end
            2: req = '1;
            default: ;
          endcase
        end
        for (int i = 0; i < N; i++) begin
          if (ack[i]) begin
            if (!(phase == 3 && $urandom_range(7) == 0)) req[i] = 1'b0;
          end else if (phase == 3 && !req[i] && $urandom_range(3) == 0) begin
            req[i] = 1'b1;
          end
        end
        if (phase == 3) wdata = (N*W)'($urandom);
      end
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("i0 reset outputs", {g_env[0].lat_c, g_env[0].lat_d, g_env[0].ack, g_env[0].busy, g_env[0].gnt_id}, '0);
    check("i1 reset outputs", {g_env[1].lat_c, g_env[1].lat_d, g_env[1].ack, g_env[1].busy, g_env[1].gnt_id}, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #2 phase = 1;
    repeat (10) @(negedge clk);
    #2 phase = 2;
    repeat (30) @(negedge clk);
    #2 phase = 3;
    repeat (3000) @(negedge clk);

    t = 0;
    while (!g_env[0].lat_c && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("i0 pulse reached before mid-op reset", 64'(g_env[0].lat_c), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("i0 async reset outputs", {g_env[0].lat_c, g_env[0].lat_d, g_env[0].ack, g_env[0].busy, g_env[0].gnt_id}, '0);
    check("i1 async reset outputs", {g_env[1].lat_c, g_env[1].lat_d, g_env[1].ack, g_env[1].busy, g_env[1].gnt_id}, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (500) @(negedge clk);

    check("i0 writes completed > 100", 64'(g_env[0].n_done > 100), 64'(1));
    check("i1 writes completed > 100", 64'(g_env[1].n_done > 100), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
